// File: rtl/ubutterfly_decoder_if.sv
// Handshake and stream bundle between a stochastic butterfly stage and its unary-to-binary decoder.
// The master drives the streams and control; the decoder side (slave) returns the decoded results.
interface ubutterfly_decoder_if #(
    parameter int unsigned BITWIDTH = 8
);
    logic iClr;
    logic iStart;
    logic iEn;
    logic iReal0;
    logic iImg0;
    logic iReal1;
    logic iImg1;
    logic iReady;
    logic oValid;
    logic oBusy;
    logic signed [BITWIDTH:0] oReal0;
    logic signed [BITWIDTH:0] oImg0;
    logic signed [BITWIDTH:0] oReal1;
    logic signed [BITWIDTH:0] oImg1;

    modport master (
        output iClr, iStart, iEn, iReal0, iImg0, iReal1, iImg1, iReady,
        input  oValid, oBusy, oReal0, oImg0, oReal1, oImg1
    );

    modport slave (
        input  iClr, iStart, iEn, iReal0, iImg0, iReal1, iImg1, iReady,
        output oValid, oBusy, oReal0, oImg0, oReal1, oImg1
    );
endinterface

// File: rtl/ubutterfly_decoder.sv
// Counts ones on four bipolar unary streams over 2^BITWIDTH enabled cycles and presents
// the signed results (count - L/2) through a valid/ready handshake.
module ubutterfly_decoder #(
    parameter int unsigned BITWIDTH = 8
) (
    input logic                   iClk,
    input logic                   iRst,
    ubutterfly_decoder_if.slave   bus
);

    localparam int unsigned NCH = 4;
    localparam logic [BITWIDTH-1:0] WIN_LAST = '1;
    localparam logic [BITWIDTH:0]   HALF     = {2'b01, {(BITWIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        HOLD
    } state_t;

    state_t              state;
    state_t              stateNext;
    logic [BITWIDTH-1:0] winCnt;
    logic [BITWIDTH:0]   onesCnt [NCH];
    logic [BITWIDTH:0]   result  [NCH];
    logic [NCH-1:0]      streamBits;
    logic                lastSample;
    logic                enterAcc;

    assign streamBits = {bus.iImg1, bus.iReal1, bus.iImg0, bus.iReal0};
    assign lastSample = (state == ACC) && bus.iEn && (winCnt == WIN_LAST);
    assign enterAcc   = (state != ACC) && (stateNext == ACC);

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        if (bus.iClr) begin
            stateNext = IDLE;
        end else begin
            unique case (state)
                IDLE:    if (bus.iStart) stateNext = ACC;
                ACC:     if (lastSample) stateNext = HOLD;
                HOLD:    if (bus.iReady) stateNext = bus.iStart ? ACC : IDLE;
                default: stateNext = IDLE;
            endcase
        end
    end

    // The final sample of the window is folded into the result in the same cycle it arrives.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            winCnt <= '0;
            for (int unsigned i = 0; i < NCH; i++) begin
                onesCnt[i] <= '0;
                result[i]  <= '0;
            end
        end else if (bus.iClr) begin
            winCnt <= '0;
            for (int unsigned i = 0; i < NCH; i++) begin
                onesCnt[i] <= '0;
                result[i]  <= '0;
            end
        end else if (enterAcc) begin
            winCnt <= '0;
            for (int unsigned i = 0; i < NCH; i++) begin
                onesCnt[i] <= '0;
            end
        end else if ((state == ACC) && bus.iEn) begin
            if (!lastSample) begin
                winCnt <= winCnt + 1'b1;
            end
            for (int unsigned i = 0; i < NCH; i++) begin
                onesCnt[i] <= onesCnt[i] + {{BITWIDTH{1'b0}}, streamBits[i]};
                if (lastSample) begin
                    result[i] <= onesCnt[i] + {{BITWIDTH{1'b0}}, streamBits[i]} - HALF;
                end
            end
        end
    end

    assign bus.oValid = (state == HOLD);
    assign bus.oBusy  = (state == ACC);
    assign bus.oReal0 = $signed(result[0]);
    assign bus.oImg0  = $signed(result[1]);
    assign bus.oReal1 = $signed(result[2]);
    assign bus.oImg1  = $signed(result[3]);

endmodule

// File: tb/tb_ubutterfly_decoder.sv
// Self-checking bench for ubutterfly_decoder at BITWIDTH=4: directed vector table, hold/clear/reset
// sequences, and random windows checked against a popcount reference model.
module tb_ubutterfly_decoder;

    localparam int unsigned BW = 4;
    localparam int          L  = 16;
    localparam int          HALFL = 8;

    logic iClk = 1'b0;
    logic iRst = 1'b1;

    ubutterfly_decoder_if #(.BITWIDTH(BW)) bus();

    ubutterfly_decoder #(.BITWIDTH(BW)) dut (
        .iClk(iClk),
        .iRst(iRst),
        .bus (bus)
    );

    always #5 iClk = ~iClk;

    typedef struct {
        logic [15:0] m0, m1, m2, m3;
        bit          toggleEn;
        int          e0, e1, e2, e3;
        int          eValid;
    } vec_t;

    vec_t vecs [5];
    int   passCnt  = 0;
    int   totalCnt = 0;
    int   expOut [4];

    task automatic step();
        @(posedge iClk);
        #1;
    endtask

    task automatic check(input string name, input longint act, input longint exp);
        totalCnt++;
        if (act == exp) passCnt++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic checkOuts(input string tag);
        check({tag, ".real0"}, longint'(bus.oReal0), longint'(expOut[0]));
        check({tag, ".img0"},  longint'(bus.oImg0),  longint'(expOut[1]));
        check({tag, ".real1"}, longint'(bus.oReal1), longint'(expOut[2]));
        check({tag, ".img1"},  longint'(bus.oImg1),  longint'(expOut[3]));
    endtask

    function automatic int decode(input logic [15:0] m);
        return $countones(m) - HALFL;
    endfunction

    task automatic randBits();
        bus.iReal0 = 1'($urandom_range(0, 1));
        bus.iImg0  = 1'($urandom_range(0, 1));
        bus.iReal1 = 1'($urandom_range(0, 1));
        bus.iImg1  = 1'($urandom_range(0, 1));
    endtask

    // Starts a window (accepting any held result in the same cycle) and feeds masks bit by bit on
    // enabled cycles. Cycle 0 is the iStart cycle; validCyc is the first cycle oValid is seen.
    task automatic runWindow(input string tag, input logic [15:0] m0, input logic [15:0] m1,
                             input logic [15:0] m2, input logic [15:0] m3,
                             input bit toggleEn, input bit randEn, output int validCyc);
        int idx;
        int cyc;
        int busyCnt;
        int lastEnCyc;
        bit en;
        idx = 0; cyc = 0; busyCnt = 0; lastEnCyc = -1; validCyc = -1;
        bus.iStart = 1'b1;
        bus.iReady = 1'b1;
        step();
        bus.iStart = 1'b0;
        bus.iReady = 1'b0;
        while (cyc < 200) begin
            cyc++;
            if (bus.oValid) begin
                validCyc = cyc;
                break;
            end
            if (bus.oBusy) busyCnt++;
            if (toggleEn)     en = (cyc % 2 == 0);
            else if (randEn)  en = ($urandom_range(0, 2) != 0);
            else              en = 1'b1;
            bus.iEn = en;
            if (en && idx < L) begin
                bus.iReal0 = m0[idx];
                bus.iImg0  = m1[idx];
                bus.iReal1 = m2[idx];
                bus.iImg1  = m3[idx];
                idx++;
                if (idx == L) lastEnCyc = cyc;
            end else begin
                randBits();
            end
            bus.iStart = randEn ? 1'($urandom_range(0, 1)) : 1'b0;
            step();
        end
        bus.iEn    = 1'b0;
        bus.iStart = 1'b0;
        check({tag, ".validCycle"}, validCyc, lastEnCyc + 1);
        check({tag, ".busyCycles"}, busyCnt, lastEnCyc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int vc;
        int bad;
        logic [15:0] r0, r1, r2, r3;

        vecs[0] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b0,  8,  8,  8,  8, 17};
        vecs[1] = '{16'h0000, 16'h5555, 16'h0FFF, 16'h000F, 1'b0, -8,  0,  4, -4, 17};
        vecs[2] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b1,  8,  8,  8,  8, 33};
        vecs[3] = '{16'h0001, 16'h7FFF, 16'h8000, 16'hFFFE, 1'b0, -7,  7, -7,  7, 17};
        vecs[4] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b1, -8, -8, -8, -8, 33};

        bus.iClr = 1'b0; bus.iStart = 1'b0; bus.iEn = 1'b0; bus.iReady = 1'b0;
        bus.iReal0 = 1'b0; bus.iImg0 = 1'b0; bus.iReal1 = 1'b0; bus.iImg1 = 1'b0;
        for (int j = 0; j < 4; j++) expOut[j] = 0;

        #2;
        check("reset.valid", longint'(bus.oValid), 0);
        check("reset.busy",  longint'(bus.oBusy),  0);
        checkOuts("reset");
        #10;
        iRst = 1'b0;
        step();
        check("idle.valid", longint'(bus.oValid), 0);

        for (int i = 0; i < 5; i++) begin
            if (i % 2 == 1) begin
                bus.iReady = 1'b1;
                step();
                bus.iReady = 1'b0;
                check($sformatf("vec%0d.acceptValid", i), longint'(bus.oValid), 0);
                checkOuts($sformatf("vec%0d.retained", i));
            end
            runWindow($sformatf("vec%0d", i), vecs[i].m0, vecs[i].m1, vecs[i].m2, vecs[i].m3,
                      vecs[i].toggleEn, 1'b0, vc);
            check($sformatf("vec%0d.latency", i), vc, vecs[i].eValid);
            expOut[0] = vecs[i].e0; expOut[1] = vecs[i].e1;
            expOut[2] = vecs[i].e2; expOut[3] = vecs[i].e3;
            checkOuts($sformatf("vec%0d", i));
        end

        // Hold with iReady low, then back-to-back accept+start.
        runWindow("hold", 16'h0000, 16'h5555, 16'h0FFF, 16'h000F, 1'b0, 1'b0, vc);
        expOut[0] = decode(16'h0000); expOut[1] = decode(16'h5555);
        expOut[2] = decode(16'h0FFF); expOut[3] = decode(16'h000F);
        for (int k = 0; k < 10; k++) begin
            bus.iReady = 1'b0;
            bus.iStart = (k % 3 == 0);
            bus.iEn    = 1'b1;
            randBits();
            step();
            check($sformatf("hold%0d.valid", k), longint'(bus.oValid), 1);
            checkOuts($sformatf("hold%0d", k));
        end
        bus.iStart = 1'b0;
        runWindow("b2b", 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, vc);
        check("b2b.latency", vc, 17);
        for (int j = 0; j < 4; j++) expOut[j] = 8;
        checkOuts("b2b");

        // Synchronous clear at window cycle 7.
        bus.iReady = 1'b1; bus.iStart = 1'b1;
        step();
        bus.iReady = 1'b0; bus.iStart = 1'b0;
        check("clr.busy", longint'(bus.oBusy), 1);
        checkOuts("clr.retained");
        for (int w = 0; w < 7; w++) begin
            bus.iEn = 1'b1;
            bus.iReal0 = 1'b1; bus.iImg0 = 1'b1; bus.iReal1 = 1'b1; bus.iImg1 = 1'b1;
            step();
        end
        bus.iClr = 1'b1; bus.iStart = 1'b1;
        step();
        bus.iClr = 1'b0; bus.iStart = 1'b0;
        check("clr.busyAfter",  longint'(bus.oBusy),  0);
        check("clr.validAfter", longint'(bus.oValid), 0);
        for (int j = 0; j < 4; j++) expOut[j] = 0;
        checkOuts("clr");
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            bus.iEn = 1'b1;
            step();
            if (bus.oValid || bus.oBusy) bad++;
        end
        check("clr.staysIdle", bad, 0);
        runWindow("postclr", 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, vc);
        for (int j = 0; j < 4; j++) expOut[j] = 8;
        checkOuts("postclr");

        // Asynchronous reset in the middle of a window.
        bus.iReady = 1'b1; bus.iStart = 1'b1;
        step();
        bus.iReady = 1'b0; bus.iStart = 1'b0;
        bus.iEn = 1'b1;
        bus.iReal0 = 1'b1; bus.iImg0 = 1'b1; bus.iReal1 = 1'b1; bus.iImg1 = 1'b1;
        repeat (5) step();
        check("rst.busyBefore", longint'(bus.oBusy), 1);
        #3;
        iRst = 1'b1;
        #1;
        check("rst.busy",  longint'(bus.oBusy),  0);
        check("rst.valid", longint'(bus.oValid), 0);
        for (int j = 0; j < 4; j++) expOut[j] = 0;
        checkOuts("rst");
        @(posedge iClk);
        #3;
        iRst = 1'b0;
        step();
        check("rst.idle", longint'(bus.oBusy), 0);
        runWindow("postrst", 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, vc);
        check("postrst.latency", vc, 17);
        for (int j = 0; j < 4; j++) expOut[j] = 8;
        checkOuts("postrst");

        // Random windows against the popcount model.
        for (int r = 0; r < 12; r++) begin
            r0 = 16'($urandom()); r1 = 16'($urandom());
            r2 = 16'($urandom()); r3 = 16'($urandom());
            if ($urandom_range(0, 1) == 1) begin
                bus.iReady = 1'b1;
                step();
                bus.iReady = 1'b0;
                check($sformatf("rnd%0d.acceptValid", r), longint'(bus.oValid), 0);
                for (int k = 0; k < int'($urandom_range(0, 3)); k++) begin
                    bus.iEn = 1'($urandom_range(0, 1));
                    randBits();
                    step();
                end
            end
            runWindow($sformatf("rnd%0d", r), r0, r1, r2, r3, 1'b0, 1'b1, vc);
            expOut[0] = decode(r0); expOut[1] = decode(r1);
            expOut[2] = decode(r2); expOut[3] = decode(r3);
            checkOuts($sformatf("rnd%0d", r));
        end

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule

// File: doc/ubutterfly_decoder.md
Name: ubutterfly_decoder

Overview:
- Converts the four bipolar unary bitstreams leaving a stochastic FFT butterfly stage (Real0, Img0, Real1, Img1) back into signed binary samples.
- Counts ones per channel over a window of 2^BITWIDTH enabled cycles, then presents the four results with a valid/ready handshake.
- Sits at the output boundary of the SFFT datapath, feeding binary consumers such as a result buffer or bus interface.

Parameters:
- BITWIDTH, 8, log2 of window length L = 2^BITWIDTH; must match the generating stream length.

Ports:
- iClk  input  1  clock, rising-edge.
- iRst  input  1  asynchronous active-high reset.
- iClr  input  1  synchronous clear (abort window, drop pending result).
- iStart  input  1  request a new decode window.
- iEn  input  1  sample-enable; stream bits are valid only when high.
- iReal0  input  1  bipolar unary stream, output 0 real.
- iImg0  input  1  bipolar unary stream, output 0 imaginary.
- iReal1  input  1  bipolar unary stream, output 1 real.
- iImg1  input  1  bipolar unary stream, output 1 imaginary.
- iReady  input  1  consumer accepts result.
- oValid  output  1  result registers hold a completed window.
- oBusy  output  1  window accumulation in progress.
- oReal0  output  BITWIDTH+1  signed decoded value.
- oImg0  output  BITWIDTH+1  signed decoded value.
- oReal1  output  BITWIDTH+1  signed decoded value.
- oImg1  output  BITWIDTH+1  signed decoded value.

Behaviour:
- Reset (iRst high, async): state IDLE; window counter, all four ones-counters, all outputs = 0.
- FSM states are IDLE, ACC and HOLD; oBusy = (state==ACC); oValid = (state==HOLD), registered.
- IDLE:
  - iStart=1 → ACC next cycle.
  - Entering ACC clears the window counter (BITWIDTH bits) and the ones-counters (BITWIDTH+1 bits each).
- ACC, iEn=1:
  - Each ones-counter increments by its stream bit.
  - Window counter increments.
- ACC, iEn=0: everything holds; the window does not advance. iStart is ignored in ACC.
- Window completion: on the enabled cycle where window counter == L-1, the bit of that cycle is included in the count.
  - The output registers load out = count − 2^(BITWIDTH-1), signed, BITWIDTH+1 bits.
  - The state moves to HOLD, so oValid rises on the next cycle.
- Latency: iStart sampled at cycle t; the first stream bit is sampled at t+1. With iEn held high, oValid=1 at t+L+1.
- Range of decoded values:
  - All-ones window → +2^(BITWIDTH-1).
  - All-zeros window → −2^(BITWIDTH-1).
  - 50% density → 0.
  - No saturation is needed; the range fits exactly.
- HOLD: outputs are stable and do not change while oValid=1.
  - iReady=1 accepts the result. In the same cycle, iStart=1 → ACC (back-to-back window, counters cleared), else → IDLE.
  - iReady=0 → stay in HOLD. iStart is ignored; no request is queued.
  - Stream bits arriving in HOLD or IDLE are discarded.
- Output data after acceptance: data ports retain the last result; only oValid drops.
- iClr=1 (sync) has highest priority below reset, in any state:
  - State → IDLE; counters → 0; oValid → 0.
  - Data outputs → 0.
  - An iStart in the same cycle is ignored.
- Reset mid-window: immediate abort, all as reset values; no partial result is ever presented.
- Counter width: the ones-counter reaches L only on the final cycle, and BITWIDTH+1 bits hold it without wrap. The window counter wraps to 0 only via re-entry to ACC.

Test Plan:
- BITWIDTH=4, all four streams held at 1, iEn=1, iStart pulse at cycle 0 → oValid=1 at cycle 17; all outputs = +8; oBusy high cycles 1–16.
- Streams = 0 (Real0), alternating 1/0 (Img0), 1 for the first 12 of 16 bits (Real1), 1 for the first 4 of 16 bits (Img1) → outputs −8, 0, +4, −4.
- iEn toggled 1/0 every cycle during ACC with all-ones streams → oValid at cycle 33; values are still +8, proving only enabled cycles count.
- Result held with iReady=0 for 10 cycles → oValid and data stable, extra iStart pulses ignored. Then iReady=1 together with iStart=1 → oBusy=1 next cycle, and the second window decodes independently.
- iClr asserted at window cycle 7 → IDLE, oValid stays 0, outputs 0. A later iStart gives a correct full-window result.
- iRst pulsed asynchronously mid-window (between clock edges) → outputs and flags 0 immediately. After release, iStart with all-ones input → +8.
